// File: rtl/sw_pkg.sv
// Shared switch definitions: port count, assert/negate levels and the
// output-arbiter state encoding used by osbm_arb.
package sw_pkg;

  localparam int   PORT   = 4;
  localparam logic ASSERT = 1'b1;
  localparam logic NEGATE = 1'b0;

  typedef enum logic {IDLE, BUSY} ARBSTATE;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: finds the first set request bit starting at ptr
// and wrapping modulo NIN. Purely combinational.
module rr_pick
  import sw_pkg::*;
#(
  parameter int NIN  = PORT + 1,
  parameter int SELW = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic [NIN-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            any,
  output logic [SELW-1:0] idx
);

  int pos;

  // Walk from the farthest position back toward ptr so the candidate closest
  // to ptr in rotation order is the last one written and therefore wins.
  always_comb begin
    any = NEGATE;
    idx = '0;
    pos = 0;
    for (int k = NIN - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NIN) pos = pos - NIN;
      if (req[pos[SELW-1:0]]) begin
        any = ASSERT;
        idx = pos[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/osbm_arb.sv
// Per-output-port round-robin arbiter. Grants one input for a whole packet
// and releases when that input drops its request.
// Optional idle watchdog built when OSBM_WATCHDOG_EN is defined.
module osbm_arb
  import sw_pkg::*;
#(
  parameter int NIN     = PORT + 1,
  parameter int SELW    = (NIN > 1) ? $clog2(NIN) : 1,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIN-1:0]  req,
  input  logic [NIN-1:0]  rei,
  output logic [NIN-1:0]  ack,
  output logic [SELW-1:0] sel,
  output logic            vld,
  output logic            err
);

  ARBSTATE         state_q, state_d;
  logic [SELW-1:0] owner_q, owner_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic            pickAny;
  logic [SELW-1:0] pickIdx;
  logic            timeoutHit;

  rr_pick #(
    .NIN  (NIN),
    .SELW (SELW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pickAny),
    .idx (pickIdx)
  );

  // Arbitrate only from IDLE; a release (normal or forced) advances the
  // pointer past the old owner so it drops to lowest priority next round.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pickAny) begin
          state_d = BUSY;
          owner_d = pickIdx;
        end
      end
      BUSY: begin
        if (!req[owner_q] || timeoutHit) begin
          state_d = IDLE;
          ptr_d   = (owner_q == SELW'(NIN - 1)) ? '0 : owner_q + 1'b1;
        end
      end
    endcase
  end

  // State, owner and pointer registers; reset drops any grant at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef OSBM_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign timeoutHit = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT));

  // Count owned cycles without a FIFO pop; cleared while idle so each grant
  // starts from zero, and err is raised for the first cycle after a forced release.
  always_comb begin
    cnt_d = '0;
    err_d = timeoutHit;
    if ((state_q == BUSY) && !rei[owner_q] && !timeoutHit) cnt_d = cnt_q + 1'b1;
  end

  // Watchdog counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= NEGATE;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unusedWd;

  assign timeoutHit = NEGATE;
  assign err        = NEGATE;
  assign unusedWd   = ^{rei, TIMEOUT[0]};
`endif

  // Grant is masked by the live request so it drops the same cycle the owner lets go.
  always_comb begin
    ack = '0;
    if (state_q == BUSY) ack = req & (NIN'(1) << owner_q);
  end

  assign sel = owner_q;
  assign vld = (state_q == BUSY) ? ASSERT : NEGATE;

endmodule

// File: tb/tb_osbm_arb.sv
// Directed testbench for osbm_arb with NIN=5 and TIMEOUT=8.
module tb_osbm_arb;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] rei;
  logic [4:0] ack;
  logic [2:0] sel;
  logic       vld;
  logic       err;

  int checks   = 0;
  int failures = 0;

  osbm_arb #(
    .NIN     (5),
    .TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .rei (rei),
    .ack (ack),
    .sel (sel),
    .vld (vld),
    .err (err)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] rq, input logic [4:0] re);
    rst = r;
    req = rq;
    rei = re;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] eAck, input logic [2:0] eSel,
                             input logic eVld, input logic eErr);
    checks++;
    assert (ack === eAck) else begin
      failures++;
      $error("[TB] FAIL %s ack: observed %b expected %b", tag, ack, eAck);
    end
    checks++;
    assert (sel === eSel) else begin
      failures++;
      $error("[TB] FAIL %s sel: observed %0d expected %0d", tag, sel, eSel);
    end
    checks++;
    assert (vld === eVld) else begin
      failures++;
      $error("[TB] FAIL %s vld: observed %b expected %b", tag, vld, eVld);
    end
    checks++;
    assert (err === eErr) else begin
      failures++;
      $error("[TB] FAIL %s err: observed %b expected %b", tag, err, eErr);
    end
  endtask

  int          order[4] = '{4, 0, 1, 4};
  logic [4:0]  oneHot;

  initial begin
    rst = 1'b1;
    req = '0;
    rei = '0;

    // Reset state
    applyStimulus(1'b1, 5'b00000, 5'b00000);
    tick();
    tick();
    checkOutput("reset", 5'b00000, 3'd0, 1'b0, 1'b0);

    // Single packet from input 2, four cycles long
    applyStimulus(1'b0, 5'b00100, 5'b00000);
    checkOutput("t1_before_edge", 5'b00000, 3'd0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("t1_busy", 5'b00100, 3'd2, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 5'b00000, 5'b00000);
    checkOutput("t1_ack_drop", 5'b00000, 3'd2, 1'b1, 1'b0);
    tick();
    checkOutput("t1_vld_drop", 5'b00000, 3'd2, 1'b0, 1'b0);

    // Round-robin order with inputs 0, 1, 4 always competing (ptr starts at 3)
    for (int p = 0; p < 4; p++) begin
      oneHot = 5'b00001 << order[p];
      applyStimulus(1'b0, 5'b10011, 5'b00000);
      for (int c = 0; c < 3; c++) begin
        tick();
        checkOutput("t2_grant", oneHot, 3'(order[p]), 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 5'b10011 & ~oneHot, 5'b00000);
      checkOutput("t2_release", 5'b00000, 3'(order[p]), 1'b1, 1'b0);
      tick();
      checkOutput("t2_gap", 5'b00000, 3'(order[p]), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 5'b00000, 5'b00000);

    // No preemption: input 0 arrives while input 1 owns the port
    applyStimulus(1'b0, 5'b00010, 5'b00000);
    tick();
    checkOutput("t3_own1", 5'b00010, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00011, 5'b00000);
    checkOutput("t3_req0_mid", 5'b00010, 3'd1, 1'b1, 1'b0);
    tick();
    checkOutput("t3_no_preempt", 5'b00010, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00001, 5'b00000);
    checkOutput("t3_drop1", 5'b00000, 3'd1, 1'b1, 1'b0);
    tick();
    checkOutput("t3_gap", 5'b00000, 3'd1, 1'b0, 1'b0);
    tick();
    checkOutput("t3_grant0", 5'b00001, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00000, 5'b00000);
    tick();

    // Reset while busy (ptr is 1 here, so only a cleared ptr picks input 0 next)
    applyStimulus(1'b0, 5'b00100, 5'b00000);
    tick();
    checkOutput("t4_own2", 5'b00100, 3'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'b00100, 5'b00000);
    tick();
    checkOutput("t4_reset_busy", 5'b00000, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'b00101, 5'b00000);
    tick();
    checkOutput("t4_after_reset", 5'b00001, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00100, 5'b00000);
    tick();
    checkOutput("t4_gap", 5'b00000, 3'd0, 1'b0, 1'b0);
    tick();
    checkOutput("t4_grant2", 5'b00100, 3'd2, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00000, 5'b00000);
    tick();

    // Release of owner 4 coincides with new requests; pointer wraps to 0
    applyStimulus(1'b0, 5'b10000, 5'b00000);
    tick();
    checkOutput("t5_own4", 5'b10000, 3'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b01001, 5'b00000);
    checkOutput("t5_release", 5'b00000, 3'd4, 1'b1, 1'b0);
    tick();
    checkOutput("t5_gap", 5'b00000, 3'd4, 1'b0, 1'b0);
    tick();
    checkOutput("t5_wrap_grant0", 5'b00001, 3'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00000, 5'b00000);
    tick();

    // A single requester wins every packet
    for (int p = 0; p < 2; p++) begin
      applyStimulus(1'b0, 5'b01000, 5'b00000);
      tick();
      checkOutput("single_req3", 5'b01000, 3'd3, 1'b1, 1'b0);
      applyStimulus(1'b0, 5'b00000, 5'b00000);
      tick();
      checkOutput("single_idle", 5'b00000, 3'd3, 1'b0, 1'b0);
    end

    // Request pulse that vanishes before the edge is never granted
    applyStimulus(1'b0, 5'b00010, 5'b00000);
    applyStimulus(1'b0, 5'b00000, 5'b00000);
    tick();
    checkOutput("glitch_ignored", 5'b00000, 3'd3, 1'b0, 1'b0);

    // Stalled owner 3 with input 4 waiting (ptr is 4 here)
    applyStimulus(1'b0, 5'b01000, 5'b00000);
    tick();
    checkOutput("wd_own3", 5'b01000, 3'd3, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b11000, 5'b00000);
`ifdef OSBM_WATCHDOG_EN
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput("wd_counting", 5'b01000, 3'd3, 1'b1, 1'b0);
    end
    tick();
    checkOutput("wd_forced_idle", 5'b00000, 3'd3, 1'b0, 1'b1);
    tick();
    checkOutput("wd_next_owner4", 5'b10000, 3'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00000, 5'b00000);
    tick();
    checkOutput("wd_end", 5'b00000, 3'd4, 1'b0, 1'b0);
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      checkOutput("nowd_held", 5'b01000, 3'd3, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 5'b10000, 5'b00000);
    tick();
    checkOutput("nowd_gap", 5'b00000, 3'd3, 1'b0, 1'b0);
    tick();
    checkOutput("nowd_owner4", 5'b10000, 3'd4, 1'b1, 1'b0);
    applyStimulus(1'b0, 5'b00000, 5'b00000);
    tick();
    checkOutput("nowd_end", 5'b00000, 3'd4, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
